// File: rtl/line_draw_pkg.sv
// rtl/line_draw_pkg.sv - shared coordinate, vertex and state types for the line command sequencer
package line_draw_pkg;

  localparam int COORD_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   pen;
    coord_t x;
    coord_t y;
  } vertex_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GO    = 2'd1,
    S_START = 2'd2,
    S_DRAW  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/line_cmd_fifo.sv
// rtl/line_cmd_fifo.sv - synchronous vertex FIFO; head is read straight from the storage registers
module line_cmd_fifo
  import line_draw_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  vertex_t       wdata_i,
  input  logic          pop_i,
  output vertex_t       rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  vertex_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     level_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (level_q == DEPTH_L);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when the same cycle also pops.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/line_cmd_seq.sv
// rtl/line_cmd_seq.sv - polyline sequencer feeding the line engine; LINE_SEQ_SKIP_DEGEN_EN turns
// pen-down vertices equal to the pen position into plain moves
module line_cmd_seq
  import line_draw_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COORD_W-1:0] cmd_x_i,
  input  logic [COORD_W-1:0] cmd_y_i,
  input  logic               cmd_pen_i,
  output logic               go_o,
  input  logic               busy_i,
  output logic [COORD_W-1:0] stax_o,
  output logic [COORD_W-1:0] stay_o,
  output logic [COORD_W-1:0] endx_o,
  output logic [COORD_W-1:0] endy_o,
  output logic [AW:0]        level_o,
  output logic               idle_o
);

  seq_state_e  state_q;
  logic        go_q;
  coord_t      stax_q, stay_q, endx_q, endy_q;
  coord_t      pen_x_q, pen_y_q;
  vertex_t     head;
  vertex_t     cmd_in;
  logic        full, empty;
  logic        push, pop, skip;

  assign cmd_in      = '{pen: cmd_pen_i, x: cmd_x_i, y: cmd_y_i};
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  // The engine may still be finishing a line after a reset, so launches wait on busy even in S_IDLE.
  assign pop         = (state_q == S_IDLE) && !empty && !busy_i;

`ifdef LINE_SEQ_SKIP_DEGEN_EN
  assign skip = (head.x == pen_x_q) && (head.y == pen_y_q);
`else
  assign skip = 1'b0;
`endif

  line_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (pclk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      stax_q  <= '0;
      stay_q  <= '0;
      endx_q  <= '0;
      endy_q  <= '0;
      pen_x_q <= '0;
      pen_y_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            pen_x_q <= head.x;
            pen_y_q <= head.y;
            if (head.pen && !skip) begin
              stax_q  <= pen_x_q;
              stay_q  <= pen_y_q;
              endx_q  <= head.x;
              endy_q  <= head.y;
              go_q    <= 1'b1;
              state_q <= S_GO;
            end
          end
        end
        S_GO: begin
          go_q    <= 1'b0;
          state_q <= S_START;
        end
        S_START: begin
          if (busy_i) begin
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (!busy_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign go_o   = go_q;
  assign stax_o = stax_q;
  assign stay_o = stay_q;
  assign endx_o = endx_q;
  assign endy_o = endy_q;
  assign idle_o = empty && (state_q == S_IDLE) && !busy_i;

endmodule

// File: tb/tb_line_cmd_seq.sv
// tb/tb_line_cmd_seq.sv - scoreboard bench for line_cmd_seq with a simple busy-holding line engine
module tb_line_cmd_seq;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        pclk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_x_i = '0;
  logic [7:0]  cmd_y_i = '0;
  logic        cmd_pen_i = 1'b0;
  logic        go_o;
  logic        busy_i = 1'b0;
  logic [7:0]  stax_o, stay_o, endx_o, endy_o;
  logic [AW:0] level_o;
  logic        idle_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cur_line = '0;
  logic [31:0] e;
  bit          have_cur = 0;
  bit          fall_valid = 0;
  bit          gap_en = 0;
  bit          force_busy = 0;
  bit          old_busy;
  int          fall_cyc = 0;
  int          eng_cnt = 0;
  int          eng_len = 5;
  int          go_cnt = 0;
  logic [7:0]  mpx = '0;
  logic [7:0]  mpy = '0;

  line_cmd_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .pclk_i      (pclk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_x_i     (cmd_x_i),
    .cmd_y_i     (cmd_y_i),
    .cmd_pen_i   (cmd_pen_i),
    .go_o        (go_o),
    .busy_i      (busy_i),
    .stax_o      (stax_o),
    .stay_o      (stay_o),
    .endx_o      (endx_o),
    .endy_o      (endy_o),
    .level_o     (level_o),
    .idle_o      (idle_o)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor plus engine model: busy rises in the go cycle and stays up eng_len cycles.
  always @(negedge pclk) begin
    if (rst_i) begin
      have_cur   = 0;
      fall_valid = 0;
    end else if (go_o) begin
      go_cnt++;
      check("go_busy_low", 32'(busy_i), 32'(0));
      if (exp_q.size() == 0) begin
        check("go_unexpected", 32'(go_o), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("line", {stax_o, stay_o, endx_o, endy_o}, e);
        cur_line = e;
        have_cur = 1;
      end
      if (fall_valid) begin
        check("go_gap", 32'(cyc - fall_cyc), 32'(2));
        fall_valid = 0;
      end
    end
    if (!rst_i && have_cur && busy_i)
      check("hold", {stax_o, stay_o, endx_o, endy_o}, cur_line);
    old_busy = busy_i;
    if (go_o) eng_cnt = eng_len;
    else if (eng_cnt != 0) eng_cnt--;
    busy_i = (eng_cnt != 0) || force_busy;
    if (old_busy && !busy_i && gap_en && exp_q.size() != 0 && !rst_i) begin
      fall_valid = 1;
      fall_cyc   = cyc;
    end
  end

  task automatic try_push(input logic [7:0] x, input logic [7:0] y, input logic pen, output bit acc);
    cmd_valid_i = 1'b1;
    cmd_x_i     = x;
    cmd_y_i     = y;
    cmd_pen_i   = pen;
    @(negedge pclk);
    acc = cmd_ready_o;
    if (acc) begin
`ifdef LINE_SEQ_SKIP_DEGEN_EN
      if (pen && !(x == mpx && y == mpy)) exp_q.push_back({mpx, mpy, x, y});
`else
      if (pen) exp_q.push_back({mpx, mpy, x, y});
`endif
      mpx = x;
      mpy = y;
    end
    @(posedge pclk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic push_cmd(input logic [7:0] x, input logic [7:0] y, input logic pen);
    bit acc;
    try_push(x, y, pen, acc);
    check("push_acc", 32'(acc), 32'(1));
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge pclk);
      #1;
      if (idle_o && exp_q.size() == 0) done = 1;
    end
    check("idle_reached", 32'(done), 32'(1));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  initial begin
    bit acc;
    int g0;
    bit seen;

    tick(3);
    rst_i = 1'b0;
    tick(1);

    // 1: reset state, then move + draw
    check("rst_go", 32'(go_o), 32'(0));
    check("rst_coords", {stax_o, stay_o, endx_o, endy_o}, 32'(0));
    check("rst_level", 32'(level_o), 32'(0));
    check("rst_ready", 32'(cmd_ready_o), 32'(1));
    check("rst_idle", 32'(idle_o), 32'(1));
    gap_en = 1;
    push_cmd(8'd10, 8'd20, 1'b0);
    push_cmd(8'd50, 8'd60, 1'b1);
    wait_idle(200);

    // 2: four back-to-back draws, go two cycles after busy falls
    g0 = go_cnt;
    push_cmd(8'd30, 8'd31, 1'b1);
    push_cmd(8'd40, 8'd41, 1'b1);
    push_cmd(8'd55, 8'd52, 1'b1);
    push_cmd(8'd255, 8'd0, 1'b1);
    wait_idle(300);
    check("t2_go_count", 32'(go_cnt - g0), 32'(4));
    gap_en = 0;

    // 3: fill while busy, extra push rejected, no pop until busy drops
    force_busy = 1;
    tick(1);
    for (int i = 0; i < DEPTH; i++) push_cmd(8'(i * 3), 8'(i * 5 + 1), 1'(i % 2));
    check("full_level", 32'(level_o), 32'(DEPTH));
    check("full_ready", 32'(cmd_ready_o), 32'(0));
    try_push(8'd99, 8'd99, 1'b1, acc);
    check("full_reject", 32'(acc), 32'(0));
    tick(4);
    check("full_no_pop", 32'(level_o), 32'(DEPTH));
    force_busy = 0;
    wait_idle(400);

    // 4: reset mid-draw with the engine still busy
    push_cmd(8'd100, 8'd100, 1'b1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (busy_i) seen = 1;
    end
    check("t4_busy_seen", 32'(seen), 32'(1));
    force_busy = 1;
    tick(2);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    exp_q.delete();
    mpx = '0;
    mpy = '0;
    check("mid_rst_go", 32'(go_o), 32'(0));
    check("mid_rst_level", 32'(level_o), 32'(0));
    check("mid_rst_coords", {stax_o, stay_o, endx_o, endy_o}, 32'(0));
    check("mid_rst_ready", 32'(cmd_ready_o), 32'(1));
    push_cmd(8'd5, 8'd5, 1'b1);
    tick(6);
    check("mid_rst_held", 32'(level_o), 32'(1));
    check("mid_rst_no_go", 32'(exp_q.size()), 32'(1));
    force_busy = 0;
    wait_idle(200);

    // 5: degenerate draw to the current pen position
    gap_en = 1;
    push_cmd(8'd3, 8'd3, 1'b0);
    g0 = go_cnt;
    push_cmd(8'd3, 8'd3, 1'b1);
    push_cmd(8'd7, 8'd8, 1'b1);
    wait_idle(200);
`ifdef LINE_SEQ_SKIP_DEGEN_EN
    check("degen_go_count", 32'(go_cnt - g0), 32'(1));
`else
    check("degen_go_count", 32'(go_cnt - g0), 32'(2));
`endif
    gap_en = 0;

    // 6: simultaneous push and pop at level 2
    force_busy = 1;
    tick(1);
    push_cmd(8'd20, 8'd21, 1'b1);
    push_cmd(8'd22, 8'd23, 1'b1);
    check("pp_level_before", 32'(level_o), 32'(2));
    force_busy = 0;
    push_cmd(8'd24, 8'd25, 1'b1);
    check("pp_level_after", 32'(level_o), 32'(2));
    wait_idle(300);
    check("final_level", 32'(level_o), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
